// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: architectural register count and the
// hazard controller state encoding.
package rv32i_types;

   localparam int unsigned NUM_ARCH_REGS = 32;
   localparam int unsigned REG_IDX_W     = 5;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: cache/issue status in, per-register
// load/flush and PC steering out.
interface pipeline_hazard_ctrl_if
   import rv32i_types::*;
#(
   parameter int unsigned NUM_PREGS = 4,
   parameter int unsigned LAT_W     = 3
);
   logic                 imem_resp;
   logic                 dmem_req;
   logic                 dmem_resp;
   logic                 issue_valid;
   logic [REG_IDX_W-1:0] issue_rs1;
   logic [REG_IDX_W-1:0] issue_rs2;
   logic [REG_IDX_W-1:0] issue_rd;
   logic                 issue_use_rs1;
   logic                 issue_use_rs2;
   logic [LAT_W-1:0]     issue_lat;
   logic                 redirect;

   logic [NUM_PREGS-1:0] preg_load;
   logic [NUM_PREGS-1:0] preg_flush;
   logic                 load_pc;
   logic                 redirect_take;
   logic                 global_stall;

   modport master (
      output imem_resp, dmem_req, dmem_resp, issue_valid,
             issue_rs1, issue_rs2, issue_rd, issue_use_rs1, issue_use_rs2,
             issue_lat, redirect,
      input  preg_load, preg_flush, load_pc, redirect_take, global_stall
   );

   modport slave (
      input  imem_resp, dmem_req, dmem_resp, issue_valid,
             issue_rs1, issue_rs2, issue_rd, issue_use_rs1, issue_use_rs2,
             issue_lat, redirect,
      output preg_load, preg_flush, load_pc, redirect_take, global_stall
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Per-architectural-register countdown of cycles until a pending result is
// forwardable; two read ports report whether a source is still busy.
module hazard_scoreboard
   import rv32i_types::*;
#(
   parameter int unsigned LAT_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 advance_i,
   input  logic                 set_i,
   input  logic [REG_IDX_W-1:0] set_rd_i,
   input  logic [LAT_W-1:0]     set_lat_i,
   input  logic [REG_IDX_W-1:0] rs1_i,
   input  logic [REG_IDX_W-1:0] rs2_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o
);

   logic [LAT_W-1:0] cnt_q [NUM_ARCH_REGS];
   logic [LAT_W-1:0] cnt_d [NUM_ARCH_REGS];

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] c);
      return (c == '0) ? c : c - LAT_W'(1);
   endfunction

   // A new producer takes the larger of its latency and the decayed count.
   always_comb begin
      for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (advance_i) begin
            cnt_d[r] = sat_dec(cnt_q[r]);
            if (set_i && (r != 0) && (set_rd_i == REG_IDX_W'(r)) &&
                (set_lat_i > cnt_d[r])) begin
               cnt_d[r] = set_lat_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rs1_busy_o = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
   assign rs2_busy_o = (rs2_i != '0) && (cnt_q[rs2_i] != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the in-order RV32I pipeline.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import rv32i_types::*;
#(
   parameter int unsigned NUM_PREGS = 4,
   parameter int unsigned ISSUE_IDX = 1,
   parameter int unsigned LAT_W     = 3,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned PERF_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave bus,
   output logic                  mem_timeout,
   output logic [PERF_W-1:0]     perf_stall,
   output logic [PERF_W-1:0]     perf_bubble,
   output logic [PERF_W-1:0]     perf_flush
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam logic [NUM_PREGS-1:0] UPSTREAM_MASK =
      NUM_PREGS'((64'd1 << ISSUE_IDX) - 64'd1);
   localparam logic [NUM_PREGS-1:0] ISSUE_MASK = NUM_PREGS'(64'd1 << ISSUE_IDX);

   hazctrl_state_t  state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   logic frozen;
   logic hazard;
   logic redir_cycle;
   logic rs1_busy, rs2_busy;
   logic sb_set;

   assign frozen = (state_q == MEM_WAIT) | (bus.dmem_req & ~bus.dmem_resp) |
                   ~bus.imem_resp;
   assign hazard = ~frozen & bus.issue_valid &
                   ((bus.issue_use_rs1 & rs1_busy) | (bus.issue_use_rs2 & rs2_busy));
   assign redir_cycle = ~frozen & ~hazard & bus.redirect;
   assign sb_set = ~frozen & ~hazard & bus.issue_valid &
                   (bus.issue_rd != '0) & (bus.issue_lat != '0);

   hazard_scoreboard #(.LAT_W(LAT_W)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .advance_i (~frozen),
      .set_i     (sb_set),
      .set_rd_i  (bus.issue_rd),
      .set_lat_i (bus.issue_lat),
      .rs1_i     (bus.issue_rs1),
      .rs2_i     (bus.issue_rs2),
      .rs1_busy_o(rs1_busy),
      .rs2_busy_o(rs2_busy)
   );

   // Data-miss FSM with a watchdog that latches a sticky timeout.
   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      timeout_d = timeout_q;
      case (state_q)
         RUN: begin
            if (bus.dmem_req && !bus.dmem_resp) begin
               state_d = MEM_WAIT;
               wd_d    = '0;
            end
         end
         MEM_WAIT: begin
            if (bus.dmem_resp) state_d = RUN;
            if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_W'(TIMEOUT)) timeout_d = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;

   // Pipeline steering, highest priority first.
   always_comb begin
      bus.preg_load     = '1;
      bus.preg_flush    = '0;
      bus.load_pc       = 1'b1;
      bus.redirect_take = 1'b0;
      bus.global_stall  = 1'b0;
      if (rst) begin
         bus.preg_load  = '0;
         bus.preg_flush = '1;
         bus.load_pc    = 1'b0;
      end else if (frozen) begin
         bus.preg_load    = '0;
         bus.load_pc      = 1'b0;
         bus.global_stall = 1'b1;
      end else if (hazard) begin
         bus.preg_load  = ~UPSTREAM_MASK;
         bus.preg_flush = ISSUE_MASK;
         bus.load_pc    = 1'b0;
      end else if (bus.redirect) begin
         bus.preg_flush    = UPSTREAM_MASK;
         bus.redirect_take = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] stall_q, bubble_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         if (frozen && (stall_q != '1))       stall_q  <= stall_q + PERF_W'(1);
         if (hazard && (bubble_q != '1))      bubble_q <= bubble_q + PERF_W'(1);
         if (redir_cycle && (flush_q != '1))  flush_q  <= flush_q + PERF_W'(1);
      end
   end

   assign perf_stall  = stall_q;
   assign perf_bubble = bubble_q;
   assign perf_flush  = flush_q;
`else
   assign perf_stall  = '0;
   assign perf_bubble = '0;
   assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a
// behavioural model of the pipeline control rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned NP = 4;
   localparam int unsigned II = 1;
   localparam int unsigned LW = 3;
   localparam int unsigned TO = 255;
   localparam int unsigned PW = 32;

   logic clk = 1'b0;
   logic rst;
   logic mem_timeout;
   logic [PW-1:0] perf_stall, perf_bubble, perf_flush;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.NUM_PREGS(NP), .LAT_W(LW)) bus ();

   pipeline_hazard_ctrl #(
      .NUM_PREGS(NP), .ISSUE_IDX(II), .LAT_W(LW), .TIMEOUT(TO), .PERF_W(PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .mem_timeout(mem_timeout),
      .perf_stall (perf_stall),
      .perf_bubble(perf_bubble),
      .perf_flush (perf_flush)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   int     sb [32];
   bit     m_miss;
   int     m_wait;
   bit     m_tmo;
   longint m_ps, m_pb, m_pf;

   // Observed outputs from the latest cycle
   logic [NP-1:0] obs_load, obs_flush;
   logic          obs_stall;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic idle_inputs();
      bus.imem_resp     = 1'b1;
      bus.dmem_req      = 1'b0;
      bus.dmem_resp     = 1'b0;
      bus.issue_valid   = 1'b0;
      bus.issue_rs1     = '0;
      bus.issue_rs2     = '0;
      bus.issue_rd      = '0;
      bus.issue_use_rs1 = 1'b0;
      bus.issue_use_rs2 = 1'b0;
      bus.issue_lat     = '0;
      bus.redirect      = 1'b0;
   endtask

   task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input int lat);
      bus.issue_valid   = 1'b1;
      bus.issue_rs1     = 5'(rs1);
      bus.issue_rs2     = 5'(rs2);
      bus.issue_use_rs1 = u1;
      bus.issue_use_rs2 = u2;
      bus.issue_rd      = 5'(rd);
      bus.issue_lat     = 3'(lat);
   endtask

   // One clock: inputs already driven after a negedge.
   task automatic cycle();
      bit frz, haz, busy1, busy2;
      logic [NP-1:0] e_load, e_flush;
      bit e_lpc, e_take;
      #1;
      busy1 = bus.issue_use_rs1 && (bus.issue_rs1 != 0) && (sb[bus.issue_rs1] > 0);
      busy2 = bus.issue_use_rs2 && (bus.issue_rs2 != 0) && (sb[bus.issue_rs2] > 0);
      frz   = m_miss || (bus.dmem_req && !bus.dmem_resp) || !bus.imem_resp;
      haz   = !frz && bus.issue_valid && (busy1 || busy2);
      e_load = '1; e_flush = '0; e_lpc = 1'b1; e_take = 1'b0;
      if (rst) begin
         e_load = '0; e_flush = '1; e_lpc = 1'b0;
      end else if (frz) begin
         e_load = '0; e_lpc = 1'b0;
      end else if (haz) begin
         for (int i = 0; i < NP; i++) e_load[i] = (i >= II);
         e_flush[II] = 1'b1;
         e_lpc = 1'b0;
      end else if (bus.redirect) begin
         for (int i = 0; i < NP; i++) e_flush[i] = (i < II);
         e_take = 1'b1;
      end
      obs_load  = bus.preg_load;
      obs_flush = bus.preg_flush;
      obs_stall = bus.global_stall;
      check_val("preg_load", bus.preg_load, e_load);
      check_val("preg_flush", bus.preg_flush, e_flush);
      check_val("load_pc", bus.load_pc, e_lpc);
      check_val("redirect_take", bus.redirect_take, e_take);
      check_val("global_stall", bus.global_stall, !rst && frz);

      @(posedge clk);
      if (rst) begin
         foreach (sb[r]) sb[r] = 0;
         m_miss = 0; m_wait = 0; m_tmo = 0;
         m_ps = 0; m_pb = 0; m_pf = 0;
      end else begin
         if (!frz) begin
            foreach (sb[r]) if (sb[r] > 0) sb[r]--;
            if (bus.issue_valid && !haz && bus.issue_rd != 0 &&
                bus.issue_lat != 0 && int'(bus.issue_lat) > sb[bus.issue_rd])
               sb[bus.issue_rd] = int'(bus.issue_lat);
         end
         if (frz) m_ps++;
         if (haz) m_pb++;
         if (!frz && !haz && bus.redirect) m_pf++;
         if (m_miss) begin
            m_wait++;
            if (m_wait >= TO) m_tmo = 1;
            if (bus.dmem_resp) m_miss = 0;
         end else if (bus.dmem_req && !bus.dmem_resp) begin
            m_miss = 1;
            m_wait = 0;
         end
      end
      #1;
      check_val("mem_timeout", mem_timeout, m_tmo);
`ifdef HAZ_PERF_CNT_EN
      check_val("perf_stall", perf_stall, m_ps);
      check_val("perf_bubble", perf_bubble, m_pb);
      check_val("perf_flush", perf_flush, m_pf);
`else
      check_val("perf_stall", perf_stall, 0);
      check_val("perf_bubble", perf_bubble, 0);
      check_val("perf_flush", perf_flush, 0);
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      foreach (sb[r]) sb[r] = 0;
      m_miss = 0; m_wait = 0; m_tmo = 0; m_ps = 0; m_pb = 0; m_pf = 0;
      @(negedge clk);
      do_reset();

      // Load-use: x5 lat 2, dependent add stalls exactly 2 cycles
      idle_inputs(); issue(0, 0, 0, 0, 5, 2); cycle();
      idle_inputs(); issue(5, 1, 1, 1, 6, 0);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (obs_load[0]) break;
         if (obs_flush[II]) n++;
      end
      check_val("loaduse_bubbles", n, 2);

      // Imem miss for 4 cycles with a pending x5 producer
      idle_inputs(); issue(0, 0, 0, 0, 5, 2); cycle();
      idle_inputs(); bus.imem_resp = 1'b0;
      n = 0;
      repeat (4) begin cycle(); if (obs_stall) n++; end
      idle_inputs(); cycle(); if (obs_stall) n++;
      check_val("imem_stall_cycles", n, 4);
      idle_inputs(); issue(5, 1, 0, 0, 0, 0); cycle();

      // Redirect without and with a RAW hazard on x7
      idle_inputs(); bus.redirect = 1'b1; cycle();
      idle_inputs(); issue(0, 0, 0, 0, 7, 3); cycle();
      idle_inputs(); issue(0, 0, 7, 1, 8, 0); bus.redirect = 1'b1; cycle();
      idle_inputs(); repeat (3) cycle();

      // x0 is never marked
      idle_inputs(); issue(0, 0, 0, 0, 0, 3); cycle();
      idle_inputs(); issue(0, 1, 0, 1, 9, 0); cycle();
      check_val("x0_no_hazard", obs_load[0], 1'b1);

      // Same-cycle data response: no stall
      idle_inputs(); bus.dmem_req = 1'b1; bus.dmem_resp = 1'b1; cycle();
      check_val("dmem_hit_no_stall", obs_stall, 1'b0);

      // Long data miss trips the watchdog, which stays set afterwards
      idle_inputs(); bus.dmem_req = 1'b1;
      repeat (300) cycle();
      bus.dmem_resp = 1'b1; cycle();
      idle_inputs(); repeat (3) cycle();
      check_val("timeout_sticky", mem_timeout, 1'b1);

      // Reset in the middle of a data miss returns to RUN
      do_reset();
      idle_inputs(); bus.dmem_req = 1'b1; repeat (5) cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      idle_inputs(); cycle();
      check_val("rst_mid_miss_run", obs_stall, 1'b0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         bus.imem_resp = ($urandom_range(0, 9) != 0);
         bus.dmem_req  = ($urandom_range(0, 9) < 2);
         bus.dmem_resp = ($urandom_range(0, 2) == 0);
         bus.redirect  = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 4) != 0)
            issue($urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7)
                                              : $urandom_range(0, 2));
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         cycle();
         rst = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised stall/flush controller for the in-order RV32I pipeline, replacing hard-coded per-opcode hazard checks with a register scoreboard of producer latencies. It sits beside the pipeline registers and drives per-register load and flush, `load_pc`, `pc_MUX_sel` redirect and `global_stall`. It arbitrates instruction-cache misses, data-cache misses (with a timeout watchdog), RAW hazards at issue and front-end redirects from branch/jump resolution.

## Interface
Parameters:
- NUM_PREGS, 4, number of pipeline registers; index 0 = IF/ID … NUM_PREGS-1 = MEM/WB
- ISSUE_IDX, 1, register the issuing instruction is latched into (ID/EX)
- LAT_W, 3, width of per-register latency countdown
- TIMEOUT, 255, data-miss cycles before `mem_timeout` sets
- PERF_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_resp  in  1  I-cache response for current fetch
- dmem_req  in  1  MEM-stage instruction performs a load or store
- dmem_resp  in  1  D-cache response
- issue_valid  in  1  ID holds a real instruction
- issue_rs1, issue_rs2, issue_rd  in  5 each  register ids
- issue_use_rs1, issue_use_rs2  in  1 each  operand actually read
- issue_lat  in  LAT_W  cycles until the issuing result is forwardable; 0 = no tracking
- redirect  in  1  ID resolved a mispredict/BTB miss; fetch must restart
- preg_load  out  NUM_PREGS  load enable per pipeline register
- preg_flush  out  NUM_PREGS  flush (bubble) per pipeline register
- load_pc  out  1  PC register load
- redirect_take  out  1  PC mux must select resolved target
- global_stall  out  1  whole pipeline frozen
- mem_timeout  out  1  sticky watchdog error
- perf_stall, perf_bubble, perf_flush  out  PERF_W each  counters

## Operation
- FSM states RUN, MEM_WAIT. RUN→MEM_WAIT when `dmem_req & ~dmem_resp`; MEM_WAIT→RUN on `dmem_resp`. rst → RUN.
- Priority per cycle (highest first):
  - frozen: state MEM_WAIT, data miss in RUN, or `~imem_resp`. Effect: all `preg_load`=0, `load_pc`=0, `global_stall`=1, no flushes, scoreboard unchanged.
  - hazard: `issue_valid` and a used rs ≠ x0 with scoreboard count ≠ 0. Effect: `preg_load[ISSUE_IDX-1:0]`=0, `load_pc`=0, `preg_flush[ISSUE_IDX]`=1, later registers load; `redirect` ignored.
  - redirect: `preg_flush[ISSUE_IDX-1:0]`=1, `redirect_take`=1, all loads 1.
  - default: all loads 1, no flush.
- Scoreboard: NUM_REGS=32 counters of LAT_W bits.
  - Each non-frozen cycle every nonzero count decrements by 1.
  - On a non-frozen, non-hazard issue with rd ≠ 0 and `issue_lat` ≠ 0, count[rd] = max(count[rd]-1 saturated, issue_lat). Set beats decrement on the same register.
  - x0 is never marked.
- Watchdog: cycle counter clears on entry to MEM_WAIT and increments while in MEM_WAIT. Reaching TIMEOUT sets `mem_timeout`, which holds until rst.

## Timing
- Control outputs are combinational from state, scoreboard and inputs in the same cycle. Scoreboard, FSM and counters update on `posedge clk`.
- While rst=1: all `preg_load`=0, all `preg_flush`=1, `load_pc`=0, `redirect_take`=0, `global_stall`=0.
- Reset values: scoreboard all 0, state RUN, `mem_timeout`=0, perf counters 0.
- Load-use with `issue_lat`=2: dependent instruction stalls exactly 2 cycles, 1 bubble each. It issues on the 3rd cycle.
- A data miss resolving on the same cycle it is requested (`dmem_resp`=1) produces no stall.
- Imem miss during MEM_WAIT: the freeze continues until both misses resolve.
- rst mid-MEM_WAIT → RUN on the next edge; watchdog cleared.

## Configuration
- `HAZ_PERF_CNT_EN` defined: `perf_stall` counts frozen cycles, `perf_bubble` counts hazard cycles, `perf_flush` counts redirect cycles. All three saturate at all-ones.
- Not defined: the three ports are driven constant 0 and no counter flops are built.

## Structure
- Shared package `rv32i_types`: `hazctrl_state_t` enum (RUN, MEM_WAIT), `NUM_ARCH_REGS`=32.
- Sub-module `hazard_scoreboard`: counter array, decrement/set/max logic, 2-port busy lookup. It is instantiated once.

## Test plan
- x5 issued with lat=2, then `add x6,x5,x1` → 2 hazard cycles with `preg_flush[1]`=1 and `preg_load[0]`=0, then issue; `perf_bubble`=2.
- `imem_resp`=0 for 4 cycles → `global_stall`=1 and all loads 0 for exactly 4 cycles; scoreboard counts frozen.
- `dmem_req`=1, `dmem_resp` delayed 300 cycles with TIMEOUT=255 → `mem_timeout` rises after 255 MEM_WAIT cycles and stays 1 after RUN resumes.
- `redirect`=1, no hazard → `preg_flush[0]`=1, `redirect_take`=1, all loads 1.
- `redirect`=1 with RAW hazard on x7 → hazard response only, `redirect_take`=0.
- Issue rd=x0 with lat=3, then read x0 → no hazard; scoreboard stays all 0.
